// File: rtl/shot_launcher.sv
// shot_launcher
// Player-side projectile controller with three shot slots. A debounced fire
// press launches a shot from the player sprite on the next unpaused frame
// strobe. Active shots move right once per frame in 1/64-pixel fixed point.
// A shot is retired when the dragon collision detector reports a hit on its
// slot, or when it passes the right edge of the screen.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   startOfFrame        one-cycle pulse per video frame
//   pause               level; freezes motion, launch and cooldown
//   fireReq             debounced fire button level
//   playerTopLeftX/Y    signed player sprite position, pixels
//   shotDragonCollision bit i = slot i hit the dragon this cycle
//   shotTopLeftX/Y      3 x 11-bit signed pixel positions, slot i at [11i+10:11i]
//   shotActive          bit i = slot i in flight
//   shotLaunched        one-cycle pulse when a launch is committed
module shot_launcher #(
    parameter int X_SPEED         = 256,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int LAUNCH_OFFSET_X = 32,
    parameter int LAUNCH_OFFSET_Y = 16,
    parameter int RIGHT_LIMIT     = 639,
    parameter int PARK_POS        = -64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               pause,
    input  logic               fireReq,
    input  logic signed [10:0] playerTopLeftX,
    input  logic signed [10:0] playerTopLeftY,
    input  logic [2:0]         shotDragonCollision,
    output logic [32:0]        shotTopLeftX,
    output logic [32:0]        shotTopLeftY,
    output logic [2:0]         shotActive,
    output logic               shotLaunched
);

    localparam int NSLOT = 3;
    localparam int PW    = 17;
    localparam int CW    = $clog2(COOLDOWN_FRAMES + 1);

    localparam logic signed [PW-1:0] PARK_FP  = PW'(PARK_POS * 64);
    localparam logic signed [10:0]   PARK_PX  = 11'(PARK_POS);
    localparam logic signed [10:0]   LIMIT_PX = 11'(RIGHT_LIMIT);

    logic signed [PW-1:0] x_q [NSLOT];
    logic signed [PW-1:0] x_d [NSLOT];
    logic signed [PW-1:0] y_q [NSLOT];
    logic signed [PW-1:0] y_d [NSLOT];
    logic [NSLOT-1:0]     act_q, act_d;
    logic [CW-1:0]        cd_q, cd_d;
    logic                 pend_q, pend_d;
    logic                 fire_q;
    logic                 launched_q, launched_d;

    logic                 run;
    logic                 fire_edge;
    logic [NSLOT-1:0]     hit;
    logic                 free_found;
    logic [1:0]           free_idx;
    logic                 launch;
    logic signed [PW-1:0] launch_x, launch_y;
    logic signed [PW-1:0] adv;

    always_comb begin
        run       = startOfFrame & ~pause;
        fire_edge = fireReq & ~fire_q & ~pause;
        hit       = shotDragonCollision & act_q;

        // Scan downward so the lowest free index is the one left standing.
        // Uses act_q (before any clear this cycle) so a slot being retired
        // is never handed out on the same edge.
        free_found = 1'b0;
        free_idx   = 2'd0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_found = 1'b1;
                free_idx   = 2'(i);
            end
        end

        launch   = run & pend_q & (cd_q == '0) & free_found;
        launch_x = ({{(PW-11){playerTopLeftX[10]}}, playerTopLeftX} + PW'(LAUNCH_OFFSET_X)) <<< 6;
        launch_y = ({{(PW-11){playerTopLeftY[10]}}, playerTopLeftY} + PW'(LAUNCH_OFFSET_Y)) <<< 6;

        adv   = '0;
        act_d = act_q;
        for (int i = 0; i < NSLOT; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            adv    = x_q[i] + PW'(X_SPEED);
            if (hit[i]) begin
                act_d[i] = 1'b0;
                x_d[i]   = PARK_FP;
                y_d[i]   = PARK_FP;
            end else if (run && act_q[i]) begin
                if ($signed(adv[PW-1:6]) > LIMIT_PX) begin
                    act_d[i] = 1'b0;
                    x_d[i]   = PARK_FP;
                    y_d[i]   = PARK_FP;
                end else begin
                    x_d[i] = adv;
                end
            end
            if (launch && (free_idx == 2'(i))) begin
                act_d[i] = 1'b1;
                x_d[i]   = launch_x;
                y_d[i]   = launch_y;
            end
        end

        if (launch)
            cd_d = CW'(COOLDOWN_FRAMES);
        else if (run && (cd_q != '0))
            cd_d = cd_q - CW'(1);
        else
            cd_d = cd_q;

        // A request is consumed by the frame strobe whether or not it launched.
        pend_d     = run ? fire_edge : (pend_q | fire_edge);
        launched_d = launch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                x_q[i] <= PARK_FP;
                y_q[i] <= PARK_FP;
            end
            act_q      <= '0;
            cd_q       <= '0;
            pend_q     <= 1'b0;
            fire_q     <= 1'b0;
            launched_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
            end
            act_q      <= act_d;
            cd_q       <= cd_d;
            pend_q     <= pend_d;
            fire_q     <= fireReq;
            launched_q <= launched_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            shotTopLeftX[11*i +: 11] = act_q[i] ? x_q[i][PW-1:6] : PARK_PX;
            shotTopLeftY[11*i +: 11] = act_q[i] ? y_q[i][PW-1:6] : PARK_PX;
        end
    end

    assign shotActive   = act_q;
    assign shotLaunched = launched_q;

endmodule

// File: tb/tb_shot_launcher.sv
module tb_shot_launcher;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               startOfFrame = 1'b0;
    logic               pause = 1'b0;
    logic               fireReq = 1'b0;
    logic signed [10:0] playerTopLeftX = '0;
    logic signed [10:0] playerTopLeftY = '0;
    logic [2:0]         shotDragonCollision = '0;
    logic [32:0]        shotTopLeftX, shotTopLeftY;
    logic [2:0]         shotActive;
    logic               shotLaunched;

    shot_launcher dut (
        .clk                 (clk),
        .reset               (reset),
        .startOfFrame        (startOfFrame),
        .pause               (pause),
        .fireReq             (fireReq),
        .playerTopLeftX      (playerTopLeftX),
        .playerTopLeftY      (playerTopLeftY),
        .shotDragonCollision (shotDragonCollision),
        .shotTopLeftX        (shotTopLeftX),
        .shotTopLeftY        (shotTopLeftY),
        .shotActive          (shotActive),
        .shotLaunched        (shotLaunched)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  act;
        logic        launched;
        logic [32:0] x;
        logic [32:0] y;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: pixel-level game rules kept in plain integers.
    bit m_act[3];
    int m_x[3];
    int m_y[3];
    int m_cd;
    bit m_pend;
    bit m_prev;

    int p_x = 100;
    int p_y = 50;
    bit fire_lvl = 0;
    bit pause_lvl = 0;

    task automatic chk(string name, logic [32:0] got, logic [32:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic exp_t snap(bit launched);
        exp_t e;
        int   px, py;
        e.launched = launched;
        e.x = '0;
        e.y = '0;
        for (int i = 0; i < 3; i++) begin
            e.act[i] = m_act[i];
            px = m_act[i] ? (m_x[i] >>> 6) : -64;
            py = m_act[i] ? (m_y[i] >>> 6) : -64;
            e.x[11*i +: 11] = px[10:0];
            e.y[11*i +: 11] = py[10:0];
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_act[i] = 0;
            m_x[i] = -64 * 64;
            m_y[i] = -64 * 64;
        end
        m_cd = 0;
        m_pend = 0;
        m_prev = 0;
    endtask

    // One clock: drive inputs, advance the model, push the expected outputs.
    task automatic cyc(bit sof, logic [2:0] coll);
        bit run, edge_ok, launch;
        int free;
        startOfFrame        = sof;
        fireReq             = fire_lvl;
        pause               = pause_lvl;
        shotDragonCollision = coll;
        playerTopLeftX      = p_x[10:0];
        playerTopLeftY      = p_y[10:0];

        run     = sof && !pause_lvl;
        edge_ok = fire_lvl && !m_prev && !pause_lvl;
        launch  = 0;
        free    = -1;
        for (int i = 0; i < 3; i++)
            if (!m_act[i] && free < 0) free = i;
        if (run) launch = m_pend && (m_cd == 0) && (free >= 0);
        for (int i = 0; i < 3; i++) begin
            if (coll[i] && m_act[i]) begin
                m_act[i] = 0;
            end else if (run && m_act[i]) begin
                m_x[i] += 256;
                if ((m_x[i] >>> 6) > 639) m_act[i] = 0;
            end
        end
        if (launch) begin
            m_act[free] = 1;
            m_x[free] = (p_x + 32) * 64;
            m_y[free] = (p_y + 16) * 64;
            m_cd = 8;
        end else if (run && m_cd > 0) begin
            m_cd--;
        end
        if (run) m_pend = 0;
        if (edge_ok) m_pend = 1;
        m_prev = fire_lvl;

        @(posedge clk);
        #1;
        sbq.push_back(snap(launch));
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc(0, 3'b000);
    endtask

    task automatic press();
        fire_lvl = 1;
        cyc(0, 3'b000);
        fire_lvl = 0;
        cyc(0, 3'b000);
    endtask

    task automatic frame();
        cyc(1, 3'b000);
        idle(2);
    endtask

    task automatic frames(int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    // Asserts reset between edges and checks the outputs respond with no clock.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_active", 33'(shotActive), 33'h0);
        chk("rst_x", shotTopLeftX, {3{11'h7C0}});
        chk("rst_y", shotTopLeftY, {3{11'h7C0}});
        chk("rst_launched", 33'(shotLaunched), 33'h0);
        model_reset();
        fire_lvl = 0;
        pause_lvl = 0;
        startOfFrame = 0;
        fireReq = 0;
        pause = 0;
        shotDragonCollision = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: consumes one expected entry per clocked cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("active", 33'(shotActive), 33'(e.act));
                chk("launched", 33'(shotLaunched), 33'(e.launched));
                chk("pos_x", shotTopLeftX, e.x);
                chk("pos_y", shotTopLeftY, e.y);
            end
        end
    end

    initial begin
        model_reset();
        #12;
        do_reset();

        // Single launch then three frames of motion.
        p_x = 100; p_y = 50;
        press(); frame(); frames(3);

        // Cooldown drops the frame-2 request; frame 9 launches into slot 1.
        do_reset();
        press(); frame();
        frame();
        press(); frame();
        frames(6);
        press(); frame();

        // Fill the third slot, overflow request dropped, hit slot 1, reuse it.
        frames(8);
        press(); frame();
        frames(8);
        press(); frame();
        cyc(0, 3'b010);
        idle(2);
        press(); frame();
        frames(2);

        // Right-edge retirement.
        do_reset();
        p_x = 604; p_y = 20;
        press(); frame(); frame(); frame();

        // Pause freezes motion/cooldown, ignores fire, still honours hits.
        do_reset();
        p_x = 100; p_y = 50;
        press(); frame(); frames(3);
        pause_lvl = 1;
        frames(2);
        press();
        frames(3);
        cyc(0, 3'b001);
        idle(1);
        pause_lvl = 0;
        for (int k = 0; k < 6; k++) begin
            press(); frame();
        end

        // Asynchronous reset mid-flight, then first launch lands in slot 0.
        do_reset();
        p_x = 200; p_y = 100;
        press(); frame(); frames(8);
        press(); frame(); frames(2);
        do_reset();
        press(); frame(); frame();

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            bit sof;
            logic [2:0] coll;
            sof  = ($urandom_range(0, 2) == 0);
            coll = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (!sof && $urandom_range(0, 3) == 0) fire_lvl = ~fire_lvl;
            if ($urandom_range(0, 29) == 0) pause_lvl = ~pause_lvl;
            if ($urandom_range(0, 19) == 0) begin
                p_x = $urandom_range(0, 620);
                p_y = $urandom_range(0, 400);
            end
            cyc(sof, coll);
        end

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain remaining=%0d want=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shot_launcher.md
Name: shot_launcher

Overview:
- Player-side projectile controller: owns 3 shot slots, launches shots from the player position on a fire request, and moves them right once per frame in 1/64-pixel fixed point.
- Retires a shot when the dragon collision detector reports a hit on its slot, or when it leaves the right edge.
- Produces the shot positions consumed by the shot draw logic and collision detector.
- It is the other end of the shotDragonCollision[2:0] bus: bit i always refers to slot i of this block.

Parameters:
- X_SPEED, 256: per-frame X increment in fixed point (x64), i.e. 4 px/frame.
- COOLDOWN_FRAMES, 8: frames after a launch during which no new launch is accepted.
- LAUNCH_OFFSET_X, 32: pixel offset added to playerTopLeftX at launch.
- LAUNCH_OFFSET_Y, 16: pixel offset added to playerTopLeftY at launch.
- RIGHT_LIMIT, 639: pixel X beyond which a shot is retired.
- PARK_POS, -64: pixel X and Y reported for an inactive slot.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- pause  in  1  level; freezes motion, launch and cooldown
- fireReq  in  1  fire button level (already debounced)
- playerTopLeftX  in  11 signed  player sprite X, pixels
- playerTopLeftY  in  11 signed  player sprite Y, pixels
- shotDragonCollision  in  3  bit i = slot i hit dragon this cycle
- shotTopLeftX  out  33  3 x 11-bit signed; slot i at bits [11i+10:11i]
- shotTopLeftY  out  33  same packing as shotTopLeftX
- shotActive  out  3  bit i = slot i in flight
- shotLaunched  out  1  one-cycle pulse on the cycle a launch is committed

Behaviour:
- Reset (asynchronous, active-high):
  - shotActive=0; all fixed-point positions = PARK_POS*64.
  - Cooldown counter=0; firePending=0; fire edge register=0; shotLaunched=0.
  - Reset asserted mid-flight discards all shots immediately.
- Positions:
  - Each slot holds 17-bit signed fixed-point X and Y.
  - Pixel output = position >>> 6, truncated to 11 bits.
  - Inactive slots are forced to PARK_POS in both axes.
- Fire capture:
  - fireReq is registered; a rising edge (0->1) sets firePending.
  - A rising edge while pause=1 is ignored.
  - Holding fireReq high produces no further launches.
- Launch, evaluated only on startOfFrame cycles with pause=0:
  - Condition: firePending=1, cooldown=0, and at least one slot inactive in the current registered shotActive.
  - Launch uses the lowest-index free slot.
  - That slot gets X=(playerTopLeftX+LAUNCH_OFFSET_X)*64 and Y=(playerTopLeftY+LAUNCH_OFFSET_Y)*64, and its active bit is set.
  - Cooldown is loaded with COOLDOWN_FRAMES; shotLaunched=1 for exactly that cycle.
  - firePending clears on every unpaused startOfFrame whether or not a launch happened; a request with no free slot or a nonzero cooldown is dropped, not queued.
  - A newly launched slot does not move on its launch frame.
- Motion, on startOfFrame with pause=0:
  - Every slot active before the edge gets X += X_SPEED; Y is constant.
  - If the new pixel X > RIGHT_LIMIT, the slot is cleared on the same edge.
- Cooldown:
  - Decrements by 1 on each unpaused startOfFrame, saturating at 0.
  - Load takes priority over decrement.
- Collision, checked every cycle regardless of startOfFrame or pause:
  - shotDragonCollision[i]=1 with slot i active clears slot i at the next edge.
  - Clear has priority over motion in the same cycle.
  - A collision bit for an inactive slot is ignored.
  - Multiple bits at once clear all the indicated slots.
- Simultaneous collision and launch:
  - Free-slot selection uses shotActive before the clear, so the slot being cleared is not reused that cycle.
  - The launch takes the next free slot if one exists, otherwise it is dropped.
- Pause=1 freezes positions, cooldown and launch; collision clears still apply.

Test Plan:
1. Reset, player at (100,50), pulse fireReq, one startOfFrame -> slot0 active at (132,66), shotLaunched for one cycle; after 3 more frames slot0 X=144, Y=66.
2. Fire on frames 0, 2 and 9 -> launch only on frames 0 and 9 (frame 2 dropped by cooldown 8); slots 0 and 1 active.
3. Fill all 3 slots (fire every 9 frames), fire again -> no launch, no shotLaunched, firePending cleared; then assert shotDragonCollision=3'b010 -> slot1 cleared and parked at (-64,-64); next fire -> slot1 reused.
4. Shot at pixel X=636 -> next frame X=640 > 639 -> retired; shotActive bit cleared on that edge.
5. pause=1 for 5 frames with an active shot and cooldown=5 -> position and cooldown unchanged, fire edge ignored; collision during pause still clears the slot.
6. Assert reset mid-flight with 2 shots active -> shotActive=0 and outputs parked immediately, asynchronously with no clk edge; release -> first fire lands in slot0.
